fetch_stage: RTL and testbench

//  IF stage directly upstream of decode: owns the PC, issues in-order requests to instruction memory, and buffers responses.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage_fifo.sv | 56 +++++
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 tb/tb_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Buffer entries pair a fetched instruction with its PC.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RESET,
    ST_RUN
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response channel.
// The fetch stage is the master; imem is the slave.
interface fetch_stage_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO with occupancy count and flush.
// Head is read combinationally; push/pop are guarded.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push)
        wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
      if (do_pop)
        rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PCF, issues credited imem requests, buffers
// responses and drives the IF/ID register for decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          BUF_DEPTH       = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master imem,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          PCSrcE,
  input  logic [31:0]   PCTargetE,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCD,
  output logic [31:0]   PCPlus4D,
  output logic          ValidD
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(BUF_DEPTH + 1);

  fetch_state_e state_q, state_d;
  logic         run;

  logic [31:0]   pcf;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_cnt;

  logic          credit, room, accept;
  logic          live_rsp, discard_hit;

  logic [31:0]   pcq_head;
  logic          pcq_empty, pcq_full;
  logic [OW-1:0] pcq_count;

  fetch_entry_t  buf_din, buf_head;
  logic          buf_push, buf_pop;
  logic          buf_empty, buf_full;
  logic [BW-1:0] buf_count;

  logic          squash, hold, load;

  // control state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  // RESET leaves on deassert; RUN is left only by rst
  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        state_d = ST_RUN;
        run     = !rst;
      end
      ST_RUN:  run = !rst;
      default: state_d = ST_RESET;
    endcase
  end

  assign credit = (32'(outstanding) + 32'(buf_count))
                  < 32'(BUF_DEPTH);
  assign room   = 32'(outstanding) < 32'(MAX_OUTSTANDING);

  assign imem.imem_req_valid = run && !PCSrcE && credit && room;
  assign imem.imem_req_addr  = pcf;

  assign accept      = imem.imem_req_valid && imem.imem_req_ready;
  assign live_rsp    = run && imem.imem_rsp_valid;
  assign discard_hit = live_rsp && (discard_cnt != '0);

  // a response landing in the redirect cycle is stale too
  assign buf_push = live_rsp && !discard_hit && !PCSrcE;
  assign buf_din  = '{pc: pcq_head, instr: imem.imem_rsp_data};

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .flush (1'b0),
    .push  (accept),
    .pop   (live_rsp),
    .din   (pcf),
    .dout  (pcq_head),
    .empty (pcq_empty),
    .full  (pcq_full),
    .count (pcq_count)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .flush (PCSrcE),
    .push  (buf_push),
    .pop   (buf_pop),
    .din   (buf_din),
    .dout  (buf_head),
    .empty (buf_empty),
    .full  (buf_full),
    .count (buf_count)
  );

  // PCF, in-flight and stale-response counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pcf         <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(live_rsp);
      if (PCSrcE) begin
        pcf         <= PCTargetE & ~32'h3;
        discard_cnt <= outstanding - OW'(live_rsp);
      end else begin
        if (accept) pcf <= pcf + 32'd4;
        discard_cnt <= discard_cnt - OW'(discard_hit);
      end
    end
  end

  // mutually exclusive IF/ID actions, in priority order
  always_comb begin
    squash = FlushD || PCSrcE;
    hold   = !squash && StallD;
    load   = !squash && !StallD && !buf_empty;
  end

  assign buf_pop = run && load;

  // IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      unique case (1'b1)
        squash: begin
          InstrD <= NOP_INSTR;
          ValidD <= 1'b0;
        end
        hold: ValidD <= ValidD;
        load: begin
          InstrD   <= buf_head.instr;
          PCD      <= buf_head.pc;
          PCPlus4D <= buf_head.pc + 32'd4;
          ValidD   <= 1'b1;
        end
        default: begin
          InstrD <= NOP_INSTR;
          ValidD <= 1'b0;
        end
      endcase
    end
  end

  // bookkeeping invariants
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(live_rsp && pcq_empty));
      assert (!(accept && pcq_full));
      assert (!(buf_push && buf_full));
      assert (32'(pcq_count) == 32'(outstanding));
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage.
// Reference: sequential PC stream restarted by redirects.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC        (RST_PC),
    .BUF_DEPTH       (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem      (imem),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          rdy_pct = 100;

  logic [31:0] fpc, dpc;
  logic [31:0] p_instr, p_pc, p_pc4;
  logic        p_valid;
  logic        last_req_valid;
  logic [31:0] last_req_addr;
  logic [31:0] seen[$];
  int          loads = 0;

  function automatic logic [31:0] memfn(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic        acc, rspv, sq, st, r, pcs;
    logic [31:0] tgt;
    int          due;
    rspv = !rst && pend_addr.size() > 0 && pend_due[0] <= cyc;
    imem.imem_rsp_valid = rspv;
    imem.imem_rsp_data  = rspv ? memfn(pend_addr[0])
                               : 32'hDEAD_BEEF;
    imem.imem_req_ready = ($urandom_range(99) < rdy_pct);
    #1;
    last_req_valid = imem.imem_req_valid;
    last_req_addr  = imem.imem_req_addr;
    acc = imem.imem_req_valid && imem.imem_req_ready;
    r   = rst;
    pcs = PCSrcE;
    tgt = PCTargetE;
    sq  = FlushD || PCSrcE;
    st  = StallD;
    if (r) begin
      chk("req_in_reset", 32'(imem.imem_req_valid), 0);
    end else begin
      if (pcs)
        chk("req_on_redirect", 32'(imem.imem_req_valid), 0);
      if (imem.imem_req_valid) begin
        chk("req_addr", imem.imem_req_addr, fpc);
        chk("req_credit", 32'(pend_addr.size() < 2), 1);
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      pend_addr.delete();
      pend_due.delete();
      last_due = cyc;
      fpc = RST_PC;
      dpc = RST_PC;
      chk("rst_valid", 32'(ValidD), 0);
      chk("rst_instr", InstrD, NOP_INSTR);
      chk("rst_pcd", PCD, 0);
      chk("rst_pc4", PCPlus4D, 0);
    end else begin
      if (rspv) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (pcs) begin
        fpc = tgt & ~32'h3;
        dpc = tgt & ~32'h3;
      end else if (acc) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(fpc);
        pend_due.push_back(due);
        fpc = fpc + 32'd4;
      end
      if (sq) begin
        chk("sq_valid", 32'(ValidD), 0);
        chk("sq_instr", InstrD, NOP_INSTR);
        chk("sq_pcd", PCD, p_pc);
        chk("sq_pc4", PCPlus4D, p_pc4);
      end else if (st) begin
        chk("hold_valid", 32'(ValidD), 32'(p_valid));
        chk("hold_instr", InstrD, p_instr);
        chk("hold_pcd", PCD, p_pc);
      end else if (ValidD) begin
        chk("ld_pcd", PCD, dpc);
        chk("ld_instr", InstrD, memfn(dpc));
        chk("ld_pc4", PCPlus4D, dpc + 32'd4);
        seen.push_back(PCD);
        dpc = dpc + 32'd4;
        loads++;
      end else begin
        chk("bubble_instr", InstrD, NOP_INSTR);
      end
    end
    p_instr = InstrD;
    p_pc    = PCD;
    p_pc4   = PCPlus4D;
    p_valid = ValidD;
    cyc++;
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1;
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    PCTargetE = '0;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data = '0;
    fpc = RST_PC;
    dpc = RST_PC;

    repeat (3) cycle();
    chk("t1_valid", 32'(ValidD), 0);
    chk("t1_instr", InstrD, 32'h13);
    rst = 1'b0;

    cycle();
    chk("t1_first_valid", 32'(last_req_valid), 1);
    chk("t1_first_addr", last_req_addr, RST_PC);
    cycle();
    cycle();
    chk("t2_lat_valid", 32'(ValidD), 1);
    chk("t2_lat_pcd", PCD, 32'h0);
    chk("t2_lat_pc4", PCPlus4D, 32'h4);
    n = 0;
    while (!(ValidD && PCD == 32'h8) && n < 10) begin
      cycle();
      n++;
    end
    chk("t2_reach8", 32'(ValidD && PCD == 32'h8), 1);

    StallD = 1'b1;
    repeat (4) cycle();
    chk("t3_credit_stop", 32'(last_req_valid), 0);
    chk("t3_hold_pcd", PCD, 32'h8);
    StallD = 1'b0;
    cycle();
    chk("t3_rel_valid0", 32'(ValidD), 1);
    chk("t3_rel_pcd0", PCD, 32'hC);
    cycle();
    chk("t3_rel_valid1", 32'(ValidD), 1);
    chk("t3_rel_pcd1", PCD, 32'h10);

    lat_min = 3;
    lat_max = 3;
    n = 0;
    while (pend_addr.size() != 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("t4_two_inflight", 32'(pend_addr.size()), 2);
    PCSrcE = 1'b1;
    PCTargetE = 32'h103;
    cycle();
    chk("t4_no_req", 32'(last_req_valid), 0);
    PCSrcE = 1'b0;
    cycle();
    chk("t4_next_addr", last_req_addr, 32'h100);
    n = 0;
    while (!ValidD && n < 20) begin
      cycle();
      n++;
    end
    chk("t4_first_pcd", PCD, 32'h100);
    chk("t4_first_valid", 32'(ValidD), 1);

    lat_min = 1;
    lat_max = 1;
    n = 0;
    while (!ValidD && n < 20) begin
      cycle();
      n++;
    end
    StallD = 1'b1;
    FlushD = 1'b1;
    cycle();
    chk("t5_valid", 32'(ValidD), 0);
    chk("t5_instr", InstrD, NOP_INSTR);
    StallD = 1'b0;
    FlushD = 1'b0;

    rdy_pct = 50;
    lat_min = 1;
    lat_max = 3;
    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFFB;
    cycle();
    PCSrcE = 1'b0;
    seen.delete();
    n = 0;
    while (seen.size() < 3 && n < 80) begin
      cycle();
      n++;
    end
    chk("t6_wrap_cnt", 32'(seen.size() >= 3), 1);
    if (seen.size() >= 3) begin
      chk("t6_wrap0", seen[0], 32'hFFFF_FFF8);
      chk("t6_wrap1", seen[1], 32'hFFFF_FFFC);
      chk("t6_wrap2", seen[2], 32'h0000_0000);
    end

    base = loads;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) rst = 1'b1;
      if (i == 202) rst = 1'b0;
      StallD    = ($urandom_range(4) == 0);
      FlushD    = ($urandom_range(22) == 0);
      PCSrcE    = ($urandom_range(30) == 0);
      PCTargetE = $urandom;
      cycle();
    end
    StallD = 1'b0;
    FlushD = 1'b0;
    PCSrcE = 1'b0;
    chk("t6_progress", 32'(loads - base > 30), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
